tlast_frame_checker: RTL
========================

# tlast_frame_checker

Receive-side counterpart of the periodic TLAST inserter: consumes a TLAST-framed 32-bit AXI stream, checks every frame against the expected length `period`, and forwards only correctly aligned beats downstream. It sits between the framed link (e.g. DMA/FIFO output) and sample consumers. It detects short/long frames, resynchronises on the next TLAST, and exposes per-frame length and error counters for the control bus.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width
- COUNTER_WIDTH, 16, width of beat counter, `period`, `frame_length` and status counters

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- period  in  COUNTER_WIDTH  expected beats per frame; 0 disables length checking
- clear_counters  in  1  synchronous clear of `frame_count` and `error_count`
- in_valid  in  1  input stream valid
- in_data  in  DATA_WIDTH  input stream data
- in_tlast  in  1  input stream last
- in_ready  out  1  input stream ready
- out_valid  out  1  output stream valid (registered)
- out_data  out  DATA_WIDTH  output stream data (registered)
- out_tlast  out  1  output stream last (registered)
- out_ready  in  1  output stream ready
- in_sync  out  1  high while in SYNC state
- frame_length  out  COUNTER_WIDTH  beat count of last completed or aborted frame
- frame_done  out  1  one-cycle pulse per completed frame
- short_err  out  1  one-cycle pulse: TLAST before `period` beats
- long_err  out  1  one-cycle pulse: `period` beats without TLAST
- frame_count  out  COUNTER_WIDTH  completed frames, wraps modulo 2^COUNTER_WIDTH
- error_count  out  COUNTER_WIDTH  short+long errors, wraps

Reset: reset, synchronous, active-low; clock: clock.

## Operation
- Accept = in_valid & in_ready. `beat_cnt` counts accepted beats in the current frame.
- States: UNSYNC (after reset), SYNC.
- UNSYNC: in_ready = 1; beats are discarded, not forwarded. An accepted beat with in_tlast = 1 moves the block to SYNC with beat_cnt = 0. That beat is also discarded.
- SYNC: in_ready = ~out_valid | out_ready. Each accepted beat loads the output register.
- Frame end on TLAST in SYNC, with len = beat_cnt + 1:
  - If len == period, or period == 0: frame_done.
  - If len < period: frame_done and short_err; the frame is forwarded unchanged and the block stays in SYNC.
  - In both cases frame_length <= len and beat_cnt <= 0.
- Long frame: an accepted beat with beat_cnt == period - 1, in_tlast = 0 and period != 0 triggers:
  - that beat forwarded with out_tlast forced to 1
  - long_err pulse, frame_length <= period
  - transition to UNSYNC (drop until the next input TLAST)
- period == 0: beat_cnt saturates at all-ones; no errors are raised.
- `period` is compared live on every beat; a change takes effect on the next accepted beat.
- frame_count increments on frame_done. error_count increments on short_err or long_err (at most +1 per cycle).
- If clear_counters coincides with an increment, the clear wins and the result is 0.
- Reset mid-frame: the output register is invalidated, the state returns to UNSYNC, and all counters are zeroed.

## Timing
- Reset values: out_valid 0, out_data 0, out_tlast 0, in_sync 0, frame_length 0, frame_done/short_err/long_err 0, frame_count 0, error_count 0.
- Latency: 1 cycle from accept to out_valid.
- Status pulses and frame_length update in the same cycle that the corresponding beat appears on out_*. Long-frame pulses align with the forced-TLAST beat.
- in_sync rises the cycle after the resync TLAST is accepted, and falls the cycle after the long-error beat.
- Output handshake:
  - out_data/out_tlast are held stable while out_valid & ~out_ready.
  - Full throughput (1 beat/cycle) is required when out_ready = 1.
  - in_ready is combinational from out_valid/out_ready.
- Stalls never alter beat_cnt.

## Structure
- Package `tlast_checker_pkg`: state enum (UNSYNC, SYNC).
- One sub-module, `axis_output_stage`: single-entry registered AXI-stream slice carrying data + tlast, owning the ready/valid logic.
- Framing FSM, beat counter and status counters live in the top level.

## Test plan
- Reset, then 3 frames of period=4 with tlast on beat 4 each → first frame dropped (UNSYNC), frames 2–3 forwarded; frame_count=2, error_count=0, in_sync=1.
- SYNC, period=8, frame with tlast on beat 5 → 5 beats forwarded, out_tlast on 5th, short_err pulse, frame_length=5, still SYNC.
- SYNC, period=4, 7 beats then tlast → beat 4 out with out_tlast=1, long_err, frame_length=4; beats 5–8 dropped; resync after beat 8, next frame forwarded.
- Random out_ready (50%) backpressure over 100 frames of period=16 → no beat loss or duplication, data order preserved, error_count=0.
- clear_counters asserted in the same cycle as frame_done with frame_count=9 → frame_count=0.
- period=0, frames of lengths 3, 1000, 1 → all forwarded, frame_length=3/1000/1, no errors.

Source files
------------

// File: rtl/tlast_checker_pkg.sv
// tlast_checker_pkg: shared types for the TLAST frame checker
package tlast_checker_pkg;
  typedef enum logic {UNSYNC, SYNC} state_e;
endpackage

// File: rtl/axis_output_stage.sv
// axis_output_stage: single-entry registered AXI-stream slice carrying data and tlast
module axis_output_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_tlast,
  output logic                  ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_tlast,
  input  logic                  out_ready
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tlast_q, tlast_d;
  assign ready     = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tlast = tlast_q;
  always_comb begin
    valid_d = load ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    data_d  = load ? in_data : data_q;
    tlast_d = load ? in_tlast : tlast_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tlast_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tlast_q <= tlast_d;
    end
  end
endmodule

// File: rtl/tlast_frame_checker.sv
// tlast_frame_checker: checks TLAST-framed stream against period, forwards aligned beats, counts frames/errors
module tlast_frame_checker
  import tlast_checker_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COUNTER_WIDTH-1:0] period,
  input  logic                     clear_counters,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_tlast,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_tlast,
  input  logic                     out_ready,
  output logic                     in_sync,
  output logic [COUNTER_WIDTH-1:0] frame_length,
  output logic                     frame_done,
  output logic                     short_err,
  output logic                     long_err,
  output logic [COUNTER_WIDTH-1:0] frame_count,
  output logic [COUNTER_WIDTH-1:0] error_count
);
  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [COUNTER_WIDTH-1:0] frame_length_q, frame_length_d;
  logic [COUNTER_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [COUNTER_WIDTH-1:0] error_count_q, error_count_d;
  logic                     frame_done_q, frame_done_d;
  logic                     short_err_q, short_err_d;
  logic                     long_err_q, long_err_d;
  logic                     stage_ready, load, fwd_tlast, acc;
  logic [COUNTER_WIDTH-1:0] len;
  axis_output_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .in_data   (in_data),
    .in_tlast  (fwd_tlast),
    .ready     (stage_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tlast (out_tlast),
    .out_ready (out_ready)
  );
  assign in_ready     = (state_q == UNSYNC) ? 1'b1 : stage_ready;
  assign acc          = in_valid & in_ready;
  assign in_sync      = (state_q == SYNC);
  assign frame_length = frame_length_q;
  assign frame_done   = frame_done_q;
  assign short_err    = short_err_q;
  assign long_err     = long_err_q;
  assign frame_count  = frame_count_q;
  assign error_count  = error_count_q;
  // len saturates so that period == 0 never wraps the beat count
  assign len = &beat_cnt_q ? beat_cnt_q : beat_cnt_q + 1'b1;
  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    frame_length_d = frame_length_q;
    frame_done_d   = 1'b0;
    short_err_d    = 1'b0;
    long_err_d     = 1'b0;
    load           = 1'b0;
    fwd_tlast      = in_tlast;
    if (acc && state_q == UNSYNC && in_tlast) begin
      state_d    = SYNC;
      beat_cnt_d = '0;
    end else if (acc && state_q == SYNC) begin
      load = 1'b1;
      if (in_tlast) begin
        frame_done_d   = 1'b1;
        short_err_d    = (period != '0) && (len < period);
        frame_length_d = len;
        beat_cnt_d     = '0;
      end else if (period != '0 && len >= period) begin
        fwd_tlast      = 1'b1;
        long_err_d     = 1'b1;
        frame_length_d = period;
        beat_cnt_d     = '0;
        state_d        = UNSYNC;
      end else begin
        beat_cnt_d = len;
      end
    end
    // counters follow the registered pulses so a clear seen alongside a pulse wins
    frame_count_d = clear_counters ? '0 : frame_count_q + COUNTER_WIDTH'(frame_done_q);
    error_count_d = clear_counters ? '0 : error_count_q + COUNTER_WIDTH'(short_err_q | long_err_q);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= UNSYNC;
      beat_cnt_q     <= '0;
      frame_length_q <= '0;
      frame_count_q  <= '0;
      error_count_q  <= '0;
      frame_done_q   <= 1'b0;
      short_err_q    <= 1'b0;
      long_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      frame_length_q <= frame_length_d;
      frame_count_q  <= frame_count_d;
      error_count_q  <= error_count_d;
      frame_done_q   <= frame_done_d;
      short_err_q    <= short_err_d;
      long_err_q     <= long_err_d;
    end
  end
endmodule
